// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data bus responder:
// width codes, timer register offsets and the timer write bundle.
package data_bus_responder_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;
  localparam logic [1:0] WIDTH_NONE = 2'd3;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_FAULT_ADDR  = 5'h14;

  localparam logic [31:0] MMIO_SPAN = 32'd24;

  localparam int ENABLE_BIT = 0;

  typedef struct packed {
    logic        en;
    logic [4:0]  offset;
    logic [31:0] data;
  } tmr_wr_t;

endpackage

// File: rtl/machine_timer.sv
// 64-bit machine timer: prescaler, mtime/mtimecmp,
// enable control and registered compare interrupt.
import data_bus_responder_pkg::*;

module machine_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  tmr_wr_t     wr,
  input  logic [4:0]  rd_offset,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic [63:0]   mtime;
  logic [63:0]   mtime_n;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtimecmp_n;
  logic          enable;
  logic          enable_n;
  logic          tick;

  // A software write to either mtime half beats a same-cycle increment.
  always_comb begin
    tick       = enable && (presc == LAST);
    mtime_n    = tick ? mtime + 64'd1 : mtime;
    mtimecmp_n = mtimecmp;
    enable_n   = enable;
    if (wr.en) begin
      unique case (wr.offset)
        OFF_MTIME_LO:    mtime_n = {mtime[63:32], wr.data};
        OFF_MTIME_HI:    mtime_n = {wr.data, mtime[31:0]};
        OFF_MTIMECMP_LO: mtimecmp_n[31:0] = wr.data;
        OFF_MTIMECMP_HI: mtimecmp_n[63:32] = wr.data;
        OFF_CTRL:        enable_n = wr.data[ENABLE_BIT];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      enable   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (enable)
        presc <= tick ? '0 : presc + PW'(1);
      mtime    <= mtime_n;
      mtimecmp <= mtimecmp_n;
      enable   <= enable_n;
      irq      <= enable && (mtime >= mtimecmp);
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_offset)
      OFF_MTIME_LO:    rd_data = mtime[31:0];
      OFF_MTIME_HI:    rd_data = mtime[63:32];
      OFF_MTIMECMP_LO: rd_data = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_data = mtimecmp[63:32];
      OFF_CTRL:        rd_data[ENABLE_BIT] = enable;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data bus responder: access decode, lane-steered RAM,
// fault capture and the memory-mapped machine timer.
import data_bus_responder_pkg::*;

module data_bus_responder #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        irq,
  output logic        bus_fault
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0] ram [RAM_WORDS];

  logic          active;
  logic          misaligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic          fault;
  logic          rd_ok;
  logic          wr_ok;
  logic [31:0]   mmio_off;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [31:0]   ram_rdata;
  logic [31:0]   mmio_rdata;
  logic [31:0]   tmr_rdata;
  logic [31:0]   rdata;
  logic [31:0]   wmask;
  logic [31:0]   wdata;
  logic [31:0]   fault_addr;
  tmr_wr_t       tmr_wr;

  assign mmio_off = data_address - MMIO_BASE;
  assign ram_hit  = data_address < RAM_BYTES;
  assign mmio_hit = (data_address >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
  assign idx      = data_address[AW+1:2];
  assign word     = ram[idx];

  always_comb begin
    active = (data_read || data_write) && (data_width != WIDTH_NONE);
    misaligned = ((data_width == WIDTH_HALF) && data_address[0]) ||
                 ((data_width == WIDTH_WORD) && (data_address[1:0] != 2'b00));
    fault = active && ((data_read && data_write) || misaligned ||
            !(ram_hit || mmio_hit) ||
            (mmio_hit && (data_width != WIDTH_WORD)));
    rd_ok = active && data_read && !fault;
    wr_ok = active && data_write && !fault;
  end

  always_comb begin
    shifted   = word >> {data_address[1:0], 3'b000};
    ram_rdata = word;
    wmask     = '1;
    wdata     = data_out;
    unique case (data_width)
      WIDTH_BYTE: begin
        ram_rdata = {24'b0, shifted[7:0]};
        wmask     = 32'h0000_00FF << {data_address[1:0], 3'b000};
        wdata     = {4{data_out[7:0]}};
      end
      WIDTH_HALF: begin
        ram_rdata = {16'b0, shifted[15:0]};
        wmask     = 32'h0000_FFFF << {data_address[1], 4'b0000};
        wdata     = {2{data_out[15:0]}};
      end
      default: ;
    endcase
  end

  assign mmio_rdata = (mmio_off[4:0] == OFF_FAULT_ADDR) ? fault_addr : tmr_rdata;
  assign rdata      = rd_ok ? (ram_hit ? ram_rdata : mmio_rdata) : '0;
  assign data_in    = reset ? rdata : '0;

  // Gating on reset drops a write whose edge lands inside reset.
  always_ff @(posedge clock) begin
    if (reset && wr_ok && ram_hit)
      ram[idx] <= (word & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus_fault  <= 1'b0;
      fault_addr <= '0;
    end else if (fault) begin
      bus_fault  <= 1'b1;
      fault_addr <= data_address;
    end else if (wr_ok && mmio_hit && (mmio_off[4:0] == OFF_FAULT_ADDR)) begin
      bus_fault  <= 1'b0;
    end
  end

  assign tmr_wr = '{en: wr_ok && mmio_hit, offset: mmio_off[4:0], data: data_out};

  machine_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .wr        (tmr_wr),
    .rd_offset (mmio_off[4:0]),
    .rd_data   (tmr_rdata),
    .irq       (irq)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed cases plus random
// traffic against a byte-addressed reference model.
import data_bus_responder_pkg::*;

module tb_data_bus_responder;

  localparam int          RAM_WORDS = 1024;
  localparam int          RAM_BYTES = RAM_WORDS * 4;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          PRESCALE  = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_address;
  logic [1:0]  data_width;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;
  logic        irq;
  logic        bus_fault;

  always #5 clock = ~clock;

  data_bus_responder #(
    .RAM_WORDS (RAM_WORDS),
    .MMIO_BASE (BASE),
    .PRESCALE  (PRESCALE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_address (data_address),
    .data_width   (data_width),
    .data_out     (data_out),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_in      (data_in),
    .irq          (irq),
    .bus_fault    (bus_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  m_mem [RAM_BYTES];
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        m_irq;
  logic        m_bf;
  logic [31:0] m_fa;
  int          m_ps;

  logic [31:0] got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_mtime = '0;
    m_cmp   = '1;
    m_en    = 1'b0;
    m_irq   = 1'b0;
    m_bf    = 1'b0;
    m_fa    = '0;
    m_ps    = 0;
  endtask

  function automatic logic m_fault(input logic rd, input logic wr,
                                   input logic [1:0] w, input logic [31:0] a);
    if (!((rd || wr) && w != 2'd3)) return 1'b0;
    if (rd && wr) return 1'b1;
    if ((w == 2'd1 && a % 2 != 0) || (w == 2'd2 && a % 4 != 0)) return 1'b1;
    if (a < RAM_BYTES) return 1'b0;
    if (a >= BASE && a < BASE + 32'd24) return w != 2'd2;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic rd, input logic wr,
                                         input logic [1:0] w, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (!rd || w == 2'd3 || m_fault(rd, wr, w, a)) return v;
    if (a < RAM_BYTES) begin
      for (int i = 0; i < (1 << w); i++) v[8*i +: 8] = m_mem[int'(a) + i];
      return v;
    end
    case (a - BASE)
      32'h00: v = m_mtime[31:0];
      32'h04: v = m_mtime[63:32];
      32'h08: v = m_cmp[31:0];
      32'h0C: v = m_cmp[63:32];
      32'h10: v = {31'b0, m_en};
      default: v = m_fa;
    endcase
    return v;
  endfunction

  task automatic m_step(input logic rd, input logic wr, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d);
    logic        f;
    logic        tick;
    logic        irq_n;
    logic        en_n;
    logic [63:0] mt;
    f     = m_fault(rd, wr, w, a);
    tick  = m_en && (m_ps == PRESCALE - 1);
    irq_n = m_en && (m_mtime >= m_cmp);
    mt    = m_mtime + (tick ? 64'd1 : 64'd0);
    en_n  = m_en;
    if (m_en) m_ps = tick ? 0 : m_ps + 1;
    if (f) begin
      m_bf = 1'b1;
      m_fa = a;
    end else if (wr && w != 2'd3) begin
      if (a < RAM_BYTES) begin
        for (int i = 0; i < (1 << w); i++) m_mem[int'(a) + i] = d[8*i +: 8];
      end else begin
        case (a - BASE)
          32'h00: mt = {m_mtime[63:32], d};
          32'h04: mt = {d, m_mtime[31:0]};
          32'h08: m_cmp[31:0] = d;
          32'h0C: m_cmp[63:32] = d;
          32'h10: en_n = d[0];
          default: m_bf = 1'b0;
        endcase
      end
    end
    m_mtime = mt;
    m_en    = en_n;
    m_irq   = irq_n;
  endtask

  // Entered just after a rising edge; returns one cycle later.
  task automatic bus(input logic rd, input logic wr, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] obs);
    data_read    = rd;
    data_write   = wr;
    data_width   = w;
    data_address = a;
    data_out     = d;
    #3;
    obs = data_in;
    chk("data_in", data_in, m_read(rd, wr, w, a));
    @(posedge clock);
    #1;
    m_step(rd, wr, w, a, d);
    chk("irq", irq, m_irq);
    chk("bus_fault", bus_fault, m_bf);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
    logic        rd;
    logic        wr;
    int          k;

    data_read    = 1'b1;
    data_write   = 1'b0;
    data_width   = WIDTH_WORD;
    data_address = '0;
    data_out     = '0;
    m_reset();
    #2;
    chk("rst_irq", irq, 1'b0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_bus_fault", bus_fault, 1'b0);
    @(negedge clock);
    data_read = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    m_step(0, 0, 2'd3, 0, 0);

    for (int i = 0; i < 64; i++) bus(0, 1, WIDTH_WORD, 32'(i * 4), $urandom, got);
    bus(0, 1, WIDTH_WORD, 32'(RAM_BYTES - 4), 32'hCAFE_F00D, got);
    bus(1, 0, WIDTH_WORD, 32'(RAM_BYTES - 4), 0, got);
    chk("ram_top_word", got, 32'hCAFE_F00D);

    bus(0, 1, WIDTH_WORD, 32'h100, 32'h1122_3344, got);
    bus(0, 1, WIDTH_BYTE, 32'h102, 32'h0000_00AA, got);
    bus(0, 1, WIDTH_HALF, 32'h100, 32'h0000_BEEF, got);
    bus(1, 0, WIDTH_WORD, 32'h100, 0, got);
    chk("lw_100", got, 32'h11AA_BEEF);
    bus(1, 0, WIDTH_BYTE, 32'h103, 0, got);
    chk("lbu_103", got, 32'h0000_0011);
    bus(1, 0, WIDTH_HALF, 32'h102, 0, got);
    chk("lhu_102", got, 32'h0000_11AA);

    bus(0, 1, WIDTH_WORD, 32'h101, 32'hDEAD_BEEF, got);
    chk("misalign_fault", bus_fault, 1'b1);
    bus(1, 0, WIDTH_WORD, 32'h100, 0, got);
    chk("misalign_nowrite", got, 32'h11AA_BEEF);
    bus(1, 0, WIDTH_WORD, BASE + 32'h14, 0, got);
    chk("fault_addr", got, 32'h0000_0101);
    bus(0, 1, WIDTH_WORD, BASE + 32'h14, $urandom, got);
    chk("fault_clear", bus_fault, 1'b0);

    bus(1, 0, WIDTH_WORD, 32'h4000_0000, 0, got);
    chk("unmapped_rd", got, 32'h0);
    chk("unmapped_fault", bus_fault, 1'b1);
    bus(1, 0, WIDTH_WORD, BASE + 32'h14, 0, got);
    chk("unmapped_addr", got, 32'h4000_0000);
    bus(1, 0, WIDTH_WORD, 32'(RAM_BYTES), 0, got);
    chk("ram_end_rd", got, 32'h0);
    bus(1, 0, WIDTH_WORD, BASE + 32'd24, 0, got);
    chk("mmio_end_rd", got, 32'h0);
    bus(0, 1, WIDTH_WORD, BASE + 32'h14, 0, got);
    bus(0, 1, WIDTH_BYTE, BASE, 32'h55, got);
    chk("mmio_byte_fault", bus_fault, 1'b1);
    bus(1, 0, WIDTH_WORD, BASE, 0, got);
    chk("mmio_byte_nowrite", got, 32'h0);

    bus(0, 1, WIDTH_WORD, BASE + 32'h10, 0, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h04, 32'h0, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h00, 32'hFFFF_FFFF, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h0C, 32'h1, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h08, 32'h0, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h10, 32'h1, got);
    bus(1, 0, WIDTH_WORD, BASE + 32'h00, 0, got);
    chk("carry_lo_pre", got, 32'hFFFF_FFFF);
    chk("irq_not_yet", irq, 1'b0);
    bus(1, 0, WIDTH_WORD, BASE + 32'h00, 0, got);
    chk("carry_lo", got, 32'h0);
    chk("irq_rise", irq, 1'b1);
    bus(1, 0, WIDTH_WORD, BASE + 32'h04, 0, got);
    chk("carry_hi", got, 32'h1);

    bus(0, 1, WIDTH_WORD, BASE + 32'h00, 32'd5, got);
    bus(1, 0, WIDTH_WORD, BASE + 32'h00, 0, got);
    chk("collide_5", got, 32'd5);
    bus(1, 0, WIDTH_WORD, BASE + 32'h00, 0, got);
    chk("collide_6", got, 32'd6);

    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 19);
      rd = $urandom_range(0, 1) != 0;
      wr = !rd;
      w  = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      d  = $urandom;
      if (k == 12) w = WIDTH_NONE;
      else if (k == 13) begin rd = 1'b1; wr = 1'b1; end
      else if (k >= 14 && k <= 16) begin
        a = BASE + 32'(4 * $urandom_range(0, 5));
        if ($urandom_range(0, 3) != 0) w = WIDTH_WORD;
      end else if (k == 17) a = 32'(RAM_BYTES) + 32'($urandom_range(0, 32'h0FFF_FFFF));
      else if (k == 18) begin rd = 1'b0; wr = 1'b0; end
      else if (k == 19) begin a = 32'(RAM_BYTES - 4); w = WIDTH_WORD; end
      bus(rd, wr, w, a, d, got);
    end

    bus(0, 1, WIDTH_WORD, BASE + 32'h14, 0, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h0C, 0, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h08, 0, got);
    bus(0, 1, WIDTH_WORD, BASE + 32'h10, 1, got);
    bus(0, 0, WIDTH_NONE, 0, 0, got);
    bus(0, 0, WIDTH_NONE, 0, 0, got);
    chk("pre_rst_irq", irq, 1'b1);

    d = {m_mem[3], m_mem[2], m_mem[1], m_mem[0]};
    data_write   = 1'b1;
    data_read    = 1'b0;
    data_width   = WIDTH_WORD;
    data_address = 32'h0;
    data_out     = ~d;
    #2 reset = 1'b0;
    #1 chk("async_irq", irq, 1'b0);
    data_write = 1'b0;
    data_read  = 1'b1;
    #1 chk("async_data_in", data_in, 32'h0);
    data_read  = 1'b0;
    data_write = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    data_write = 1'b0;
    m_reset();
    @(posedge clock);
    #1;
    m_step(0, 0, WIDTH_WORD, 0, 0);

    bus(1, 0, WIDTH_WORD, 32'h0, 0, got);
    chk("rst_write_dropped", got, d);
    bus(1, 0, WIDTH_WORD, BASE + 32'h00, 0, got);
    chk("rst_mtime_lo", got, 32'h0);
    bus(1, 0, WIDTH_WORD, BASE + 32'h0C, 0, got);
    chk("rst_cmp_hi", got, 32'hFFFF_FFFF);
    bus(1, 0, WIDTH_WORD, BASE + 32'h10, 0, got);
    chk("rst_ctrl", got, 32'h0);
    chk("rst_irq_low", irq, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Responder end of the core's data bus. Decodes `data_address`/`data_width`/`data_read`/`data_write`, serves on-chip RAM with byte/half/word lanes, and exposes a memory-mapped 64-bit machine timer. The timer drives the core's `irq` input. Reads are zero-wait-state so the single-cycle core can consume `data_in` in the same cycle; writes and all timer state are sequential.

Parameters:
- RAM_WORDS, 1024: RAM depth in 32-bit words; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h8000_0000: base byte address of the timer register block (six words).
- PRESCALE, 1: clock cycles per mtime increment; must be >= 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-low.
- data_address  in  32  byte address from the core.
- data_width  in  2  access width: 0 byte, 1 half, 2 word, 3 no access.
- data_out  in  32  write data from the core, right-aligned.
- data_read  in  1  read request this cycle.
- data_write  in  1  write request this cycle.
- data_in  out  32  read data to the core, right-aligned and zero-extended (the core sign-extends).
- irq  out  1  timer interrupt request to the core.
- bus_fault  out  1  sticky fault flag.

Behaviour:
- Reset (reset low, asynchronous):
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; ctrl.enable = 0; bus_fault = 0; fault_addr = 0; prescaler counter = 0.
  - irq = 0 and data_in = 0 while reset is asserted.
  - RAM contents are not reset and are undefined.
- Request qualification:
  - A request is active when `data_read` or `data_write` is 1 and `data_width != 3`.
  - If both `data_read` and `data_write` are 1, the cycle is a fault.
- Alignment:
  - half requires addr[0] = 0; word requires addr[1:0] = 0.
  - A misaligned access is a fault.
- Address decode:
  - RAM hit: addr < RAM_WORDS*4.
  - MMIO hit: MMIO_BASE <= addr < MMIO_BASE+24. Only word width is legal in MMIO; byte or half there is a fault.
  - Any other address is a fault.
- Reads (combinational, same cycle):
  - RAM: the word at addr[.:2]; the selected lane is shifted down to bit 0 and the upper bits are zeroed (byte lane = addr[1:0]; half lane = addr[1]).
  - MMIO: the register value.
  - Faulted read or no active read: data_in = 0.
- Writes (rising edge):
  - RAM: only the addressed lanes are updated, using data_out[7:0] (byte) or data_out[15:0] (half) placed at the lane position. Other lanes are preserved.
  - A faulted write changes no state.
- MMIO map (word offsets from MMIO_BASE):
  - 0x00 mtime_lo (RW)
  - 0x04 mtime_hi (RW)
  - 0x08 mtimecmp_lo (RW)
  - 0x0C mtimecmp_hi (RW)
  - 0x10 ctrl (RW): bit0 enable, other bits read 0.
  - 0x14 fault_addr (R; writes are ignored and are not a fault). Any write to 0x14 clears bus_fault.
- Fault:
  - On the rising edge of a faulted cycle: bus_fault <= 1 and fault_addr <= data_address.
  - A later fault overwrites fault_addr.
  - If a fault and a write to 0x14 occur in the same cycle, the fault wins.
- Timer:
  - The prescaler counts 0..PRESCALE-1 while enable = 1. On wrap, mtime increments by 1 as a 64-bit value, with carry from lo to hi and wrap from all-ones to 0.
  - The prescaler holds its value while enable = 0.
  - A write to mtime_lo or mtime_hi in the same cycle as an increment wins: the written half takes the data, the other half keeps its pre-increment value, and the increment is dropped.
- irq:
  - Registered: irq <= enable && (mtime >= mtimecmp), compared unsigned 64-bit on post-update values.
  - irq is therefore visible 1 cycle after the condition becomes true. It stays high until software raises mtimecmp, lowers mtime, or clears enable.
- Reset mid-operation:
  - All registers return to their reset values immediately.
  - A write in progress is discarded.

Decomposition:
- Shared package holds:
  - width codes WIDTH_BYTE = 0, WIDTH_HALF = 1, WIDTH_WORD = 2, WIDTH_NONE = 3, shared with the core's load/store logic;
  - MMIO offset constants for the six registers;
  - the ctrl bit index ENABLE_BIT = 0.
- One natural sub-module: machine_timer, containing the prescaler, 64-bit mtime/mtimecmp, the compare, and the irq register. It takes a write-enable/offset/data interface.
- The lane logic, decode and RAM array stay in the top module.

Test Plan:
- Byte/half lanes: write word 0x11223344 at 0x100; sb 0xAA at 0x102; sh 0xBEEF at 0x100 -> lw 0x100 returns 0x11AABEEF; lbu 0x103 returns 0x00000011; lhu 0x102 returns 0x000011AA.
- Misalignment: sw at 0x101 -> the word at 0x100 is unchanged, bus_fault = 1, lw MMIO_BASE+0x14 returns 0x101; sw any value to MMIO_BASE+0x14 -> bus_fault = 0 next cycle.
- Unmapped and illegal MMIO width: lw 0x4000_0000 -> data_in = 0 and fault; sb to MMIO_BASE+0x00 -> mtime unchanged and fault.
- Timer carry and irq: write mtime_hi = 0, mtime_lo = 0xFFFF_FFFF, mtimecmp_hi = 1, mtimecmp_lo = 0, ctrl = 1 (PRESCALE = 1) -> next increment gives hi = 1, lo = 0; irq rises exactly 1 cycle later.
- Write versus increment collision: enable = 1 and write mtime_lo = 5 in an increment cycle -> mtime_lo reads 5 (not 6) next cycle, then 6 one cycle after.
- Async reset mid-run: irq = 1 with a pending write, pulse reset low between clock edges -> irq = 0 and data_in = 0 immediately; after release mtime = 0, mtimecmp = all ones, irq stays 0 with enable = 0.
